// File: rtl/io_sequencer.sv
// io_sequencer: retires one operation at a time from the upstream stage.
// OP_IN reads a byte from the input device and offers it for cell
// write-back, OP_OUT sends the current cell value to the output device,
// and any other operation is acknowledged with no I/O activity.
// Opcode bit layout shared with the decoder: INC=0, DEC=1, LEFT=2,
// RIGHT=3, OUT=4, IN=5, JZ=6, JNZ=7. Only OUT and IN matter here.
module io_sequencer #(
  parameter int D_WIDTH   = 8,
  parameter int CNT_WIDTH = 16,
  parameter int OPCODE_W  = 8,
  parameter int OP_OUT    = 4,
  parameter int OP_IN     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [OPCODE_W-1:0]  op_code,
  input  logic [D_WIDTH-1:0]   op_data,
  output logic                 op_ack,
  input  logic                 in_valid,
  input  logic [D_WIDTH-1:0]   in_data,
  output logic                 in_ack,
  output logic                 out_valid,
  output logic [D_WIDTH-1:0]   out_data,
  input  logic                 out_ready,
  output logic                 res_valid,
  output logic [D_WIDTH-1:0]   res_data,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] in_count,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IN  = 3'd1;
  localparam logic [2:0] S_RESULT   = 3'd2;
  localparam logic [2:0] S_WAIT_OUT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [D_WIDTH-1:0]   out_data_q, out_data_d;
  logic [D_WIDTH-1:0]   res_data_q, res_data_d;
  logic [CNT_WIDTH-1:0] in_count_q, in_count_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;

  // Next-state, data capture and counter update. Operation fields are only
  // looked at in IDLE, so upstream changes while busy cannot disturb a
  // transfer in flight. IN takes priority when both I/O bits are set.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    res_data_d  = res_data_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (op_code[OP_IN]) begin
            state_d = S_WAIT_IN;
          end else if (op_code[OP_OUT]) begin
            out_data_d = op_data;
            state_d    = S_WAIT_OUT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          res_data_d = in_data;
          state_d    = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          in_count_d = in_count_q + CNT_WIDTH'(1);
          state_d    = S_DONE;
        end
      end
      S_WAIT_OUT: begin
        if (out_ready) begin
          out_count_d = out_count_q + CNT_WIDTH'(1);
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      res_data_q  <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      res_data_q  <= res_data_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
    end
  end

  // Handshake outputs are pure state decodes; in_ack also needs in_valid
  // so the device sees its byte consumed in the same cycle it is captured.
  assign busy      = (state_q != S_IDLE);
  assign op_ack    = (state_q == S_DONE);
  assign out_valid = (state_q == S_WAIT_OUT);
  assign res_valid = (state_q == S_RESULT);
  assign in_ack    = (state_q == S_WAIT_IN) && in_valid;
  assign out_data  = out_data_q;
  assign res_data  = res_data_q;
  assign in_count  = in_count_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Scoreboard bench for io_sequencer: each operation pushes its expected
// I/O byte and acknowledge; a negedge monitor pops and compares them.
module tb_io_sequencer;

  localparam int OP_INC_B = 0;
  localparam int OP_DEC_B = 1;
  localparam int OP_OUT_B = 4;
  localparam int OP_IN_B  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [7:0] op_code;
  logic [7:0] op_data;
  logic       op_ack;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       busy;
  logic [7:0] in_count;
  logic [7:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_out_q[$];
  logic [7:0] exp_res_q[$];
  int         exp_ack_q[$];
  int         in_ack_cnt    = 0;
  int         out_valid_cyc = 0;
  logic [7:0] in_cnt_m  = 8'd0;
  logic [7:0] out_cnt_m = 8'd0;

  io_sequencer #(
    .D_WIDTH  (8),
    .CNT_WIDTH(8),
    .OPCODE_W (8),
    .OP_OUT   (OP_OUT_B),
    .OP_IN    (OP_IN_B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_data  (op_data),
    .op_ack   (op_ack),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .busy     (busy),
    .in_count (in_count),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: compares produced bytes against the scoreboard and flags
  // acknowledges or transfers nobody asked for.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_ack) begin
        in_ack_cnt++;
        check("in_ack_needs_valid", in_valid, 1);
      end
      if (out_valid) begin
        out_valid_cyc++;
        check("res_with_out", res_valid, 0);
        if (exp_out_q.size() == 0) begin
          check("out_unexpected", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_out_q[0]);
          if (out_ready) void'(exp_out_q.pop_front());
        end
      end
      if (res_valid) begin
        if (exp_res_q.size() == 0) begin
          check("res_unexpected", res_valid, 0);
        end else begin
          check("res_data", res_data, exp_res_q[0]);
          if (res_ready) void'(exp_res_q.pop_front());
        end
      end
      if (op_ack) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", op_ack, 0);
        else void'(exp_ack_q.pop_front());
      end
    end
  end

  // Issue one operation. id/rd/od: edge count after acceptance from which
  // in_valid / res_ready / out_ready are high. exp_lat: edges until op_ack.
  task automatic run_op(input string tag, input logic [7:0] code, input logic [7:0] data,
                        input int id, input logic [7:0] ib, input int rd, input int od,
                        input int exp_lat, input int exp_ov);
    int   edges;
    int   ack0;
    int   ov0;
    bit   got;
    bit   consumed;
    bit   is_in;
    bit   is_out;
    is_in  = code[OP_IN_B];
    is_out = !is_in && code[OP_OUT_B];
    if (is_in) exp_res_q.push_back(ib);
    else if (is_out) exp_out_q.push_back(data);
    exp_ack_q.push_back(1);
    ack0      = in_ack_cnt;
    ov0       = out_valid_cyc;
    op_valid  = 1'b1;
    op_code   = code;
    op_data   = data;
    in_data   = ib;
    in_valid  = (id == 0);
    out_ready = (od == 0);
    res_ready = (rd == 0);
    edges     = 0;
    got       = 1'b0;
    consumed  = 1'b0;
    while (!got && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) check({tag, "_busy"}, busy, 1);
      op_code = 8'hFF;
      op_data = ~data;
      if (in_ack_cnt != ack0) consumed = 1'b1;
      in_valid  = !consumed && (edges >= id);
      out_ready = (edges >= od);
      res_ready = (edges >= rd);
      if (op_ack) got = 1'b1;
    end
    check({tag, "_ack_seen"}, got, 1);
    check({tag, "_latency"}, edges, exp_lat);
    op_valid  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    res_ready = 1'b0;
    if (is_in) in_cnt_m = in_cnt_m + 8'd1;
    if (is_out) out_cnt_m = out_cnt_m + 8'd1;
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_ack_pulse"}, op_ack, 0);
    check({tag, "_in_acks"}, in_ack_cnt - ack0, is_in ? 1 : 0);
    check({tag, "_out_cycles"}, out_valid_cyc - ov0, exp_ov);
    check({tag, "_in_count"}, in_count, in_cnt_m);
    check({tag, "_out_count"}, out_count, out_cnt_m);
    $display("op %s code=0x%02h data=0x%02h lat=%0d in_count=%0d out_count=%0d",
             tag, code, data, edges, in_count, out_count);
  endtask

  logic [7:0] c_inc, c_dec, c_in, c_out;

  initial begin
    c_inc = 8'd1 << OP_INC_B;
    c_dec = 8'd1 << OP_DEC_B;
    c_in  = 8'd1 << OP_IN_B;
    c_out = 8'd1 << OP_OUT_B;
    reset = 1'b1; op_valid = 1'b0; op_code = 8'h00; op_data = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_op_ack", op_ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_in_count", in_count, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b0;

    run_op("inc",      c_inc,         8'h10, 99, 8'h00, 99, 99, 1, 0);
    run_op("out_slow", c_out,         8'h41, 99, 8'h00, 99, 4,  5, 4);
    run_op("in_slow",  c_in,          8'h00, 2,  8'h5A, 4,  99, 5, 0);
    run_op("in_fast",  c_in,          8'h00, 0,  8'hC3, 0,  99, 3, 0);
    run_op("out_fast", c_out,         8'hE7, 99, 8'h00, 99, 0,  2, 1);
    run_op("in_out",   c_in | c_out,  8'h77, 0,  8'h3C, 0,  0,  3, 0);
    run_op("dec",      c_dec,         8'h01, 99, 8'h00, 99, 99, 1, 0);

    // Reset while an OUT transfer is stalled on the device.
    op_valid = 1'b1; op_code = c_out; op_data = 8'h99; out_ready = 1'b0;
    exp_out_q.push_back(8'h99);
    exp_ack_q.push_back(1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("rst_mid_busy", busy, 1);
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_out_q.delete();
    exp_ack_q.delete();
    in_cnt_m = 8'd0;
    out_cnt_m = 8'd0;
    check("rst_abort_out_valid", out_valid, 0);
    check("rst_abort_busy", busy, 0);
    check("rst_abort_out_count", out_count, 0);
    check("rst_abort_in_count", in_count, 0);
    check("rst_abort_out_data", out_data, 0);
    check("rst_abort_res_data", res_data, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_abort_no_ack", op_ack, 0);
    end

    run_op("post_rst", c_inc, 8'h00, 99, 8'h00, 99, 99, 1, 0);

    // Fill the 8-bit out counter to all-ones, then wrap it.
    for (int i = 0; i < 255; i++) begin
      run_op("fill", c_out, 8'(i), 99, 8'h00, 99, 0, 2, 1);
    end
    check("count_full", out_count, 8'hFF);
    run_op("wrap", c_out, 8'hAA, 99, 8'h00, 99, 0, 2, 1);
    check("count_wrapped", out_count, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    check("ack_q_drained", exp_ack_q.size(), 0);
    check("out_q_drained", exp_out_q.size(), 0);
    check("res_q_drained", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
